// File: rtl/tap_delay_line_pkg.sv
// Shared widths and defaults for the tap_delay_line slice.
package tap_delay_line_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_DEPTH = 35;

    // Bits needed to count 0..depth valid stages.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address a stage; never narrower than one bit.
    function automatic int sel_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tap_delay_stage.sv
// One delay-line stage: a data register plus its valid flag.
// Reset clears both, flush clears only the valid, enable shifts both in.
module tap_delay_stage
    import tap_delay_line_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_ena,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Stage register: reset > flush > enable; flush leaves data in place.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_ena) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/tap_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid, clock-enable
// advance, synchronous flush, run-time tap selector and occupancy flags.
// Optional build macro TAP_DELAY_LINE_FLAT_OUT_EN adds flat views of all
// stage data (taps_flat) and valids (valids_flat).
module tap_delay_line
    import tap_delay_line_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = cnt_w(DEPTH),
    localparam int SW    = sel_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_ena,
    input  logic [WIDTH-1:0] in_stream,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [SW-1:0]    tap_sel,
    output logic [WIDTH-1:0] tap_data,
    output logic             tap_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CW-1:0]    fill_count,
    output logic             full,
    output logic             empty
`ifdef TAP_DELAY_LINE_FLAT_OUT_EN
    ,
    output logic [WIDTH*DEPTH-1:0] taps_flat,
    output logic [DEPTH-1:0]       valids_flat
`endif
);

    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [CW-1:0]    r_fill_count;

    // Stage 0 takes the input sample; every later stage takes its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] w_d_in;
            logic             w_v_in;
            if (gi == 0) begin : g_head
                assign w_d_in = in_stream;
                assign w_v_in = in_valid;
            end else begin : g_body
                assign w_d_in = w_data[gi-1];
                assign w_v_in = w_valid[gi-1];
            end
            tap_delay_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .i_reset (reset),
                .i_flush (flush),
                .i_ena   (clk_ena),
                .i_data  (w_d_in),
                .i_valid (w_v_in),
                .o_data  (w_data[gi]),
                .o_valid (w_valid[gi])
            );
        end
    endgenerate

    // Occupancy: one valid enters at the head while one may leave at the tail,
    // so the count stays exactly equal to the number of set stage valids.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_fill_count <= '0;
        end else if (clk_ena) begin
            r_fill_count <= r_fill_count + CW'(in_valid) - CW'(w_valid[DEPTH-1]);
        end
    end

    // Tap mux: out-of-range selections (non power-of-2 DEPTH) read as zero.
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == SW'(i)) begin
                tap_data  = w_data[i];
                tap_valid = w_valid[i];
            end
        end
    end

    assign out_data   = w_data[DEPTH-1];
    assign out_valid  = w_valid[DEPTH-1];
    assign fill_count = r_fill_count;
    assign full       = (r_fill_count == CW'(DEPTH));
    assign empty      = (r_fill_count == '0);

`ifdef TAP_DELAY_LINE_FLAT_OUT_EN
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign taps_flat[gi*WIDTH +: WIDTH] = w_data[gi];
        end
    endgenerate
    assign valids_flat = w_valid;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: a DEPTH=4 instance (power of two) and a DEPTH=5
// instance (out-of-range taps) share one stimulus stream.
module tb_tap_delay_line;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset     = 1'b1;
    logic       clk_ena   = 1'b0;
    logic       flush     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_stream = 8'h00;
    logic [1:0] tap_sel4  = 2'd0;
    logic [2:0] tap_sel5  = 3'd0;

    logic [7:0] td4, od4, td5, od5;
    logic       tv4, ov4, full4, empty4, tv5, ov5, full5, empty5;
    logic [2:0] fc4, fc5;
`ifdef TAP_DELAY_LINE_FLAT_OUT_EN
    logic [31:0] tf4;
    logic [3:0]  vf4;
    logic [39:0] tf5;
    logic [4:0]  vf5;
`endif

    tap_delay_line #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .clk_ena(clk_ena), .in_stream(in_stream),
        .in_valid(in_valid), .flush(flush), .tap_sel(tap_sel4),
        .tap_data(td4), .tap_valid(tv4), .out_data(od4), .out_valid(ov4),
        .fill_count(fc4), .full(full4), .empty(empty4)
`ifdef TAP_DELAY_LINE_FLAT_OUT_EN
        , .taps_flat(tf4), .valids_flat(vf4)
`endif
    );

    tap_delay_line #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .reset(reset), .clk_ena(clk_ena), .in_stream(in_stream),
        .in_valid(in_valid), .flush(flush), .tap_sel(tap_sel5),
        .tap_data(td5), .tap_valid(tv5), .out_data(od5), .out_valid(ov5),
        .fill_count(fc5), .full(full5), .empty(empty5)
`ifdef TAP_DELAY_LINE_FLAT_OUT_EN
        , .taps_flat(tf5), .valids_flat(vf5)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each line is a list of {valid,data} slots, newest at index 0.
    logic [7:0] m_d [2][5];
    logic       m_v [2][5];
    int         dep [2] = '{4, 5};
    bit         known = 1'b0;

    function automatic void model_step(input logic rst, input logic en, input logic fl,
                                       input logic vin, input logic [7:0] din);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 5; i++) begin
                    m_d[k][i] = 8'h00;
                    m_v[k][i] = 1'b0;
                end
            end else if (fl) begin
                for (int i = 0; i < 5; i++) m_v[k][i] = 1'b0;
            end else if (en) begin
                for (int i = dep[k] - 1; i > 0; i--) begin
                    m_d[k][i] = m_d[k][i-1];
                    m_v[k][i] = m_v[k][i-1];
                end
                m_d[k][0] = din;
                m_v[k][0] = vin;
            end
        end
    endfunction

    task automatic check_dut(input int k, input logic [2:0] fc, input logic fu, input logic em,
                             input logic [7:0] od, input logic ov, input logic [7:0] td,
                             input logic tv, input int sel);
        string p;
        int    pop;
        p   = (k == 0) ? "d4" : "d5";
        pop = 0;
        for (int i = 0; i < dep[k]; i++) pop += int'(m_v[k][i]);
        chk({p, "_fill"},  fc, pop);
        chk({p, "_full"},  fu, (pop == dep[k]));
        chk({p, "_empty"}, em, (pop == 0));
        chk({p, "_odata"}, od, m_d[k][dep[k]-1]);
        chk({p, "_ovalid"}, ov, m_v[k][dep[k]-1]);
        chk({p, "_tdata"}, td, (sel < dep[k]) ? m_d[k][sel] : 8'h00);
        chk({p, "_tvalid"}, tv, (sel < dep[k]) ? m_v[k][sel] : 1'b0);
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp4_q[$];
    logic [7:0] exp5_q[$];
    logic       mon_adv;

    // Monitor: each valid sample reaching the tail on an advance edge must be
    // the oldest accepted sample still in flight.
    always @(posedge clk) begin
        mon_adv = clk_ena && !flush && !reset;
        #1;
        if (mon_adv === 1'b1 && ov4 === 1'b1) begin
            if (exp4_q.size() == 0) chk("sb4_unexpected", {8'h0, od4}, 16'hffff);
            else chk("sb4_out", od4, exp4_q.pop_front());
        end
        if (mon_adv === 1'b1 && ov5 === 1'b1) begin
            if (exp5_q.size() == 0) chk("sb5_unexpected", {8'h0, od5}, 16'hffff);
            else chk("sb5_out", od5, exp5_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic en, input logic fl,
                        input logic vin, input logic [7:0] din);
        @(negedge clk);
        if (known) begin
            check_dut(0, fc4, full4, empty4, od4, ov4, td4, tv4, int'(tap_sel4));
            check_dut(1, fc5, full5, empty5, od5, ov5, td5, tv5, int'(tap_sel5));
`ifdef TAP_DELAY_LINE_FLAT_OUT_EN
            chk("d4_popcount", fc4, $countones(vf4));
            chk("d5_popcount", fc5, $countones(vf5));
`endif
        end
        reset = rst; clk_ena = en; flush = fl; in_valid = vin; in_stream = din;
        if (rst || fl) begin
            exp4_q.delete();
            exp5_q.delete();
        end else if (en && vin) begin
            exp4_q.push_back(din);
            exp5_q.push_back(din);
        end
        @(posedge clk);
        model_step(rst, en, fl, vin, din);
        if (rst) known = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       bub_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int         bub_fc [4] = '{1, 1, 2, 2};
        logic       bub_ov [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset for two cycles.
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        #1;
        chk("rst_empty", empty4, 1);
        chk("rst_full", full4, 0);
        chk("rst_fill", fc4, 0);
        chk("rst_ovalid", ov4, 0);
        chk("rst_odata", od4, 0);
        chk("rst_tvalid", tv4, 0);

        // Basic fill.
        step(0, 1, 0, 1, 8'h11);
        step(0, 1, 0, 1, 8'h22);
        step(0, 1, 0, 1, 8'h33);
        step(0, 1, 0, 1, 8'h44);
        #1;
        chk("fill_odata", od4, 8'h11);
        chk("fill_ovalid", ov4, 1);
        chk("fill_full", full4, 1);
        chk("fill_count", fc4, 4);
        chk("fill_d5_ovalid", ov5, 0);

        // Enable gating: inputs ignored while clk_ena is low.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1'($urandom), 8'($urandom));
            #1;
            chk("hold_odata", od4, 8'h11);
            chk("hold_fill", fc4, 4);
        end
        step(0, 1, 0, 1, 8'h55);
        #1;
        chk("resume_odata", od4, 8'h22);

        // Flush collides with an advance: sample dropped, no shift.
        step(0, 1, 1, 1, 8'h99);
        #1;
        chk("flush_fill", fc4, 0);
        chk("flush_empty", empty4, 1);
        chk("flush_ovalid", ov4, 0);
        chk("flush_odata", od4, 8'h22);
        chk("flush_head_data", td4, 8'h55);
        chk("flush_head_valid", tv4, 0);

        // Bubbles.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, bub_v[i], 8'hA0 + 8'(i));
            #1;
            chk("bubble_fill", fc4, bub_fc[i]);
        end
        for (int i = 0; i < 4; i++) begin
            chk("bubble_ovalid", ov4, bub_ov[i]);
            if (i < 3) begin
                step(0, 1, 0, 0, 8'h00);
                #1;
            end
        end

        // Tap sweep after pushing 1..5, then hold.
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 1, 8'(i));
        step(0, 0, 0, 0, 8'h00);
        for (int s = 0; s < 8; s++) begin
            tap_sel5 = 3'(s);
            #1;
            chk("sweep5_data", td5, (s < 5) ? 8'(5 - s) : 8'h00);
            chk("sweep5_valid", tv5, (s < 5) ? 1'b1 : 1'b0);
        end
        for (int s = 0; s < 4; s++) begin
            tap_sel4 = 2'(s);
            #1;
            chk("sweep4_data", td4, 8'(5 - s));
        end
        tap_sel4 = 2'd0;
        tap_sel5 = 3'd0;

        // Reset in the middle of continuous advance at half fill.
        step(0, 1, 1, 0, 8'h00);
        step(0, 1, 0, 1, 8'h61);
        step(0, 1, 0, 1, 8'h62);
        step(1, 1, 0, 1, 8'h63);
        #1;
        chk("mrst_fill", fc4, 0);
        chk("mrst_empty", empty4, 1);
        chk("mrst_full", full4, 0);
        chk("mrst_odata", od4, 0);
        chk("mrst_ovalid", ov4, 0);
        chk("mrst_tdata", td4, 0);
        chk("mrst_tvalid", tv4, 0);
        chk("mrst_d5_tdata", td5, 0);
`ifdef TAP_DELAY_LINE_FLAT_OUT_EN
        chk("mrst_flat4", tf4, 0);
        chk("mrst_flat5", tf5, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 8'h70 + 8'(i));
            #1;
            chk("refill_ovalid", ov4, (i == 3) ? 1'b1 : 1'b0);
        end
        chk("refill_odata", od4, 8'h70);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            tap_sel4 = 2'($urandom_range(0, 3));
            tap_sel5 = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) < 3), 1'($urandom), 8'($urandom));
        end
        step(0, 0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
